uart_mem_loader: RTL and testbench

- Upstream feeder of the unified 16-bit instruction/data memory; drives that memory's write port (wen0/waddr0/wdata0) from a host serial link.
- Receives 8N1 UART bytes, parses a framed load packet, assembles big-endian 16-bit words and writes them to consecutive addresses from 0.
- Asserts busy while a load is in progress so top level can hold the CPU; reports done/err at packet end.

---
 rtl/uart_mem_loader_if.sv | 10 +
 rtl/uart_mem_loader.sv | 181 ++++++++++++++++++
 tb/tb_uart_mem_loader.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_loader_if.sv
// Write port of the unified 16-bit instruction/data memory, as driven by the
// serial loader.
interface uart_mem_loader_if;
  logic        wen0;
  logic [15:0] waddr0;
  logic [15:0] wdata0;

  modport master (output wen0, output waddr0, output wdata0);
  modport slave  (input  wen0, input  waddr0, input  wdata0);
endinterface

// File: rtl/uart_mem_loader.sv
// Loads big-endian 16-bit words from a framed 8N1 UART packet into memory
// starting at address 0; busy/done/err report packet progress and outcome.
module uart_mem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MEM_DEPTH    = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  uart_mem_loader_if.master mem,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {F_SYNC, F_CNT_H, F_CNT_L, F_DATA_H, F_DATA_L, F_CSUM} fr_state_t;

  logic        rx_m, rx_s, rx_d;
  rx_state_t   rstate;
  logic [15:0] bcnt;
  logic [2:0]  bitn;
  logic [7:0]  shreg;
  logic [7:0]  rbyte;
  logic        bvalid;
  logic        ferr;

  // rx_d holds the previous synchronized sample for start-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate <= R_IDLE;
      bcnt   <= '0;
      bitn   <= '0;
      shreg  <= '0;
      rbyte  <= '0;
      bvalid <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      bvalid <= 1'b0;
      ferr   <= 1'b0;
      case (rstate)
        R_IDLE: begin
          bcnt <= '0;
          if (rx_d && !rx_s) rstate <= R_START;
        end
        R_START: begin
          if (bcnt == HALF_LAST) begin
            bcnt   <= '0;
            bitn   <= '0;
            rstate <= rx_s ? R_IDLE : R_DATA;
          end else begin
            bcnt <= bcnt + 16'd1;
          end
        end
        R_DATA: begin
          if (bcnt == BIT_LAST) begin
            bcnt  <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bitn == 3'd7) rstate <= R_STOP;
            bitn <= bitn + 3'd1;
          end else begin
            bcnt <= bcnt + 16'd1;
          end
        end
        R_STOP: begin
          if (bcnt == BIT_LAST) begin
            bcnt   <= '0;
            rstate <= R_IDLE;
            if (rx_s) begin
              bvalid <= 1'b1;
              rbyte  <= shreg;
            end else begin
              ferr <= 1'b1;
            end
          end else begin
            bcnt <= bcnt + 16'd1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  fr_state_t   fstate;
  logic [7:0]  cnt_hi;
  logic [7:0]  word_hi;
  logic [15:0] nwords;
  logic [15:0] idx;
  logic [7:0]  acc;
  logic [15:0] n_next;

  assign n_next = {cnt_hi, rbyte};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fstate     <= F_SYNC;
      cnt_hi     <= '0;
      word_hi    <= '0;
      nwords     <= '0;
      idx        <= '0;
      acc        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      mem.wen0   <= 1'b0;
      mem.waddr0 <= '0;
      mem.wdata0 <= '0;
    end else begin
      mem.wen0 <= 1'b0;
      // Framing errors only abort an active packet; in F_SYNC they are noise
      if (ferr && fstate != F_SYNC) begin
        err    <= 1'b1;
        busy   <= 1'b0;
        fstate <= F_SYNC;
      end else if (bvalid) begin
        case (fstate)
          F_SYNC: begin
            if (rbyte == 8'hA5) begin
              fstate <= F_CNT_H;
              busy   <= 1'b1;
              done   <= 1'b0;
              err    <= 1'b0;
              idx    <= '0;
              acc    <= '0;
            end
          end
          F_CNT_H: begin
            cnt_hi <= rbyte;
            fstate <= F_CNT_L;
          end
          F_CNT_L: begin
            if (n_next == 16'd0 || {1'b0, n_next} > 17'(MEM_DEPTH)) begin
              err    <= 1'b1;
              busy   <= 1'b0;
              fstate <= F_SYNC;
            end else begin
              nwords <= n_next;
              fstate <= F_DATA_H;
            end
          end
          F_DATA_H: begin
            word_hi <= rbyte;
            acc     <= acc ^ rbyte;
            fstate  <= F_DATA_L;
          end
          F_DATA_L: begin
            mem.wen0   <= 1'b1;
            mem.waddr0 <= idx;
            mem.wdata0 <= {word_hi, rbyte};
            acc        <= acc ^ rbyte;
            idx        <= idx + 16'd1;
            fstate     <= (idx + 16'd1 == nwords) ? F_CSUM : F_DATA_H;
          end
          F_CSUM: begin
            if (rbyte == acc) done <= 1'b1;
            else              err  <= 1'b1;
            busy   <= 1'b0;
            fstate <= F_SYNC;
          end
          default: fstate <= F_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench for uart_mem_loader: directed and randomized packets
// compared against a packet-level reference model.
module tb_uart_mem_loader;
  localparam int CPB = 4;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic busy, done, err;

  uart_mem_loader_if mif ();

  uart_mem_loader #(.CLKS_PER_BIT(CPB), .MEM_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rx),
    .mem  (mif.master),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] got_q[$];

  always @(negedge clk) if (mif.wen0) got_q.push_back({mif.waddr0, mif.wdata0});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    @(posedge clk); rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = bad_stop ? 1'b0 : 1'b1;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i], 1'b0);
  endtask

  // Reference: find the header, decode count, list the words, judge the checksum
  function automatic void model(input logic [7:0] q[$], output logic [31:0] w[$],
                                output logic d, output logic e);
    int i = 0;
    int n;
    logic [7:0] x = '0;
    w.delete();
    d = 1'b0;
    e = 1'b0;
    while (i < q.size() && q[i] != 8'hA5) i++;
    n = q[i+1] * 256 + q[i+2];
    if (n == 0 || n > DEPTH) begin
      e = 1'b1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      w.push_back({16'(k), q[i+3+2*k], q[i+4+2*k]});
      x = x ^ q[i+3+2*k] ^ q[i+4+2*k];
    end
    if (q[i+3+2*n] == x) d = 1'b1;
    else e = 1'b1;
  endfunction

  task automatic compare(input string tag, input logic [31:0] w[$], input logic d, input logic e);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({tag, "_nwr"}, 32'(got_q.size()), 32'(w.size()));
    for (int k = 0; k < w.size() && k < got_q.size(); k++)
      chk($sformatf("%s_wr%0d", tag, k), got_q[k], w[k]);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, d});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_pkt(input string tag, input logic [7:0] q[$]);
    logic [31:0] w[$];
    logic d, e;
    got_q.delete();
    send_bytes(q);
    model(q, w, d, e);
    compare(tag, w, d, e);
  endtask

  initial begin
    logic [7:0] p[$];
    logic [31:0] w[$];
    logic [31:0] none[$];
    logic d, e;
    int n;
    logic [7:0] x, b;

    #1;
    chk("rst_wen", {31'd0, mif.wen0}, 32'd0);
    chk("rst_busy", {29'd0, busy, done, err}, 32'd0);
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    run_pkt("good", '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40});
    run_pkt("badcs", '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41});
    run_pkt("zero", '{8'hA5, 8'h00, 8'h00});
    run_pkt("one", '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h07, 8'h07});
    run_pkt("n257", '{8'hA5, 8'h01, 8'h01});
    run_pkt("junk", '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51});

    // 1-clk glitch inside a packet must not inject a byte
    got_q.delete();
    p = '{8'hA5, 8'h00, 8'h01, 8'h5A, 8'h3C, 8'h66};
    send_byte(p[0], 1'b0);
    @(posedge clk); rx = 1'b0; @(posedge clk); rx = 1'b1;
    repeat (4 * CPB) @(posedge clk);
    chk("glitch_busy", {31'd0, busy}, 32'd1);
    for (int i = 1; i < p.size(); i++) send_byte(p[i], 1'b0);
    model(p, w, d, e);
    compare("glitch", w, d, e);

    // framing error on first data byte aborts the packet
    got_q.delete();
    send_bytes('{8'hA5, 8'h00, 8'h02});
    send_byte(8'h12, 1'b1);
    compare("ferr", none, 1'b0, 1'b1);

    // reset after first word of a 3-word load
    got_q.delete();
    send_bytes('{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22});
    repeat (2) @(posedge clk);
    chk("prerst_nwr", 32'(got_q.size()), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", {mif.wen0, mif.waddr0, mif.wdata0[14:0]}, 32'd0);
    chk("midrst_flags", {29'd0, busy, done, err}, 32'd0);
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    got_q.delete();
    send_bytes('{8'h33, 8'h44, 8'h55, 8'h66});
    compare("postrst", none, 1'b0, 1'b0);
    run_pkt("reload", '{8'hA5, 8'h00, 8'h02, 8'hC0, 8'hDE, 8'h0B, 8'hAD, 8'h00});

    // randomized packets with optional junk prefix and corrupted checksum
    for (int t = 0; t < 6; t++) begin
      p.delete();
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        p.push_back(b);
      end
      n = $urandom_range(1, 6);
      p.push_back(8'hA5); p.push_back(8'h00); p.push_back(8'(n));
      x = '0;
      for (int k = 0; k < 2 * n; k++) begin
        b = 8'($urandom_range(0, 255));
        x ^= b;
        p.push_back(b);
      end
      if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
      p.push_back(x);
      run_pkt($sformatf("rnd%0d", t), p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
